// File: rtl/stream_merge_scheduler.sv
// Two-producer to one-consumer token scheduler: round-robin arbitration with bounded bursts,
// a one-entry output holding register, source tagging and saturating per-source counters.
module stream_merge_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BURST  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              In1_SEND,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic [15:0]       In1_COUNT,
  output logic              In1_ACK,
  input  logic              In2_SEND,
  input  logic [DATA_W-1:0] In2_DATA,
  input  logic [15:0]       In2_COUNT,
  output logic              In2_ACK,
  input  logic              Out1_RDY,
  input  logic              Out1_ACK,
  output logic              Out1_SEND,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic [15:0]       Out1_COUNT,
  output logic              Out1_SRC,
  output logic [CNT_W-1:0]  CNT1,
  output logic [CNT_W-1:0]  CNT2
);

  typedef enum logic [1:0] {StIdle, StServe1, StServe2} state_e;

  localparam logic [7:0]       BurstLast = 8'(BURST - 1);
  localparam logic [7:0]       BurstOne  = 8'd1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e              state_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_src_q;
  logic [7:0]          burst_q;
  logic                last_q;     // source of the most recent accept: 0 = In1, 1 = In2
  logic [CNT_W-1:0]    cnt1_q;
  logic [CNT_W-1:0]    cnt2_q;

  logic space;
  logic acc1;
  logic acc2;
  logic burst_done;
  logic unused_inputs;

  assign unused_inputs = ^{In1_COUNT, In2_COUNT, Out1_ACK};

  // An emit frees the holding register in the same cycle, so accept and emit can overlap.
  assign space      = ~out_valid_q | Out1_RDY;
  assign acc1       = RESET_N & (state_q == StServe1) & In1_SEND & space;
  assign acc2       = RESET_N & (state_q == StServe2) & In2_SEND & space;
  assign burst_done = (burst_q == BurstLast);

  assign In1_ACK    = acc1;
  assign In2_ACK    = acc2;
  assign Out1_SEND  = RESET_N & out_valid_q & Out1_RDY;
  assign Out1_DATA  = out_data_q;
  assign Out1_SRC   = out_src_q;
  assign Out1_COUNT = 16'h1;
  assign CNT1       = cnt1_q;
  assign CNT2       = cnt2_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      burst_q     <= '0;
      last_q      <= 1'b1;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
    end else begin
      if (Out1_SEND) begin
        out_valid_q <= 1'b0;
      end
      if (acc1) begin
        out_valid_q <= 1'b1;
        out_data_q  <= In1_DATA;
        out_src_q   <= 1'b0;
        last_q      <= 1'b0;
        cnt1_q      <= (&cnt1_q) ? cnt1_q : cnt1_q + CntOne;
      end
      if (acc2) begin
        out_valid_q <= 1'b1;
        out_data_q  <= In2_DATA;
        out_src_q   <= 1'b1;
        last_q      <= 1'b1;
        cnt2_q      <= (&cnt2_q) ? cnt2_q : cnt2_q + CntOne;
      end

      unique case (state_q)
        StIdle: begin
          burst_q <= '0;
          if (In1_SEND && In2_SEND) begin
            state_q <= last_q ? StServe1 : StServe2;
          end else if (In1_SEND) begin
            state_q <= StServe1;
          end else if (In2_SEND) begin
            state_q <= StServe2;
          end
        end
        StServe1: begin
          if (!In1_SEND) begin
            burst_q <= '0;
            state_q <= In2_SEND ? StServe2 : StIdle;
          end else if (space) begin
            if (burst_done) begin
              burst_q <= '0;
              state_q <= In2_SEND ? StServe2 : StServe1;
            end else begin
              burst_q <= burst_q + BurstOne;
            end
          end
        end
        StServe2: begin
          if (!In2_SEND) begin
            burst_q <= '0;
            state_q <= In1_SEND ? StServe1 : StIdle;
          end else if (space) begin
            if (burst_done) begin
              burst_q <= '0;
              state_q <= In1_SEND ? StServe1 : StServe2;
            end else begin
              burst_q <= burst_q + BurstOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/stream_merge_scheduler.md
Name: stream_merge_scheduler

Overview:
- Two-producer to one-consumer token scheduler for the streaming actor fabric, using the same SEND/ACK/RDY/COUNT/DATA port protocol as the actors.
- Shares a single downstream actor input (for example an LL1-style stage) between two upstream producers.
- Arbitration is round-robin with bounded bursts, through a one-entry output holding register.
- Tags every token with its source and keeps saturating per-source token counters for debug.

Parameters:
DATA_W, 16, width of token data on all channels
BURST, 4, maximum tokens accepted from one source per grant (legal range 1 to 255)
CNT_W, 16, width of the per-source status counters

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
In1_SEND  in  1  producer 1 has a token valid on In1_DATA
In1_DATA  in  DATA_W  producer 1 token
In1_COUNT  in  16  producer 1 token count (ignored, tokens handled singly)
In1_ACK  out  1  one-cycle consume strobe to producer 1
In2_SEND  in  1  producer 2 has a token valid on In2_DATA
In2_DATA  in  DATA_W  producer 2 token
In2_COUNT  in  16  producer 2 token count (ignored)
In2_ACK  out  1  one-cycle consume strobe to producer 2
Out1_RDY  in  1  consumer can take a token this cycle
Out1_ACK  in  1  consumer acknowledge (unused, kept for interface uniformity)
Out1_SEND  out  1  token emitted this cycle
Out1_DATA  out  DATA_W  emitted token
Out1_COUNT  out  16  constant 16'h1
Out1_SRC  out  1  source of the emitted token: 0 = In1, 1 = In2
CNT1  out  CNT_W  tokens accepted from In1, saturating
CNT2  out  CNT_W  tokens accepted from In2, saturating

Behaviour:

Reset (RESET_N low, asynchronous):
- State = IDLE, out_valid = 0, burst_cnt = 0, last = 1 (so In1 wins first), CNT1 = CNT2 = 0.
- All registered outputs are 0. Out1_COUNT is 16'h1.
- In1_ACK, In2_ACK and Out1_SEND are forced low while RESET_N is low.
- Reset asserted mid-operation discards any held token. No ACK or SEND occurs in that cycle.

Output stage:
- Out1_SEND = out_valid & Out1_RDY, combinational.
- Out1_DATA and Out1_SRC are driven from the holding register.
- space = ~out_valid | Out1_RDY, so a token can be accepted and emitted in the same cycle (full throughput).
- On an emit with no accept, out_valid clears at the next edge.

FSM states: IDLE, SERVE1, SERVE2.

IDLE:
- Never ACKs.
- If both SEND are high, grant the source other than last.
- Otherwise grant whichever SEND is high; stay in IDLE if neither is.
- On a grant, burst_cnt = 0 at the next edge.

SERVEk accept:
- accept = InK_SEND & space. InK_ACK = accept, combinational, same cycle.
- At the edge: hold register <= InK_DATA, SRC <= k-1, out_valid = 1, CNTk += 1 (saturating at all ones), burst_cnt += 1, last = k.

SERVEk exit (evaluated in the same cycle, SEND values sampled that cycle):
- On the accept that makes burst_cnt reach BURST:
  - go to SERVEother if the other SEND is high,
  - else stay in SERVEk with burst_cnt = 0 if InK_SEND is high,
  - else go to IDLE.
- If InK_SEND is low: go to SERVEother (burst_cnt = 0) if the other SEND is high, else IDLE.
- If InK_SEND is high but space = 0 (stall): hold state and burst_cnt. A stall does not count toward the burst.
- The non-granted ACK is never asserted. In1_ACK & In2_ACK is never 1.

Latency:
- A token accepted at edge t is visible on Out1_DATA from t and emitted in the first cycle at or after t with Out1_RDY = 1.
- The first accept after IDLE occurs one cycle after SEND is seen in IDLE.

Boundaries:
- BURST = 1 gives strict alternation when both sources are active.
- Inputs change only after ACK (protocol). Data sampled is data at the accepting edge.
- Out1_RDY held low: at most one token is absorbed, then both ACKs stay low indefinitely.

Test Plan:
- Only In1_SEND high, 6 tokens 0x0010..0x0015, Out1_RDY = 1 -> one IDLE cycle, then one ACK per cycle. Out1 emits 0x0010..0x0015 in order with SRC = 0, CNT1 = 6, CNT2 = 0.
- Both SEND held high, BURST = 4, Out1_RDY = 1 -> emit pattern is 4 tokens SRC 0, 4 SRC 1, 4 SRC 0, with no bubble between bursts. In1_ACK & In2_ACK never both 1.
- Both active, Out1_RDY low for 5 cycles mid-burst -> exactly one token held, no ACKs during the stall. Burst count resumes after RDY returns, so the burst still totals 4 tokens.
- In1 burst in progress, In1_SEND drops after 2 tokens while In2_SEND is high -> next cycle switches to SERVE2 with burst_cnt = 0. In2 then gets 4 tokens.
- RESET_N pulsed low asynchronously while out_valid = 1 -> Out1_SEND and ACKs drop immediately, CNT1 = CNT2 = 0. After release, the first grant goes to In1 when both are requesting.
- CNT_W = 4, 20 tokens from In2 -> CNT2 saturates at 15 and stays there. Data flow is unaffected.
